matrix_stream_feeder: RTL

- Upstream stage of the matrix data loader.
- Buffers host-supplied 4-bit matrix elements in a small FIFO.
- Serialises one transfer onto the loader's nibble bus: four dimension words with ctrl_logic=1 (R1, C1, R2, C2), then R1*C1 + R2*C2 element words with ctrl_logic=0.
- The loader samples only on cycles where out_valid=1.

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/matrix_elem_fifo.sv | 48 ++++
 rtl/matrix_stream_feeder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix stream feeder.
// Header word order and feeder FSM states live here.
package matrix_pkg;

    localparam int DATA_W = 4;
    localparam int DIM_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        FIN  = 2'd3
    } feeder_state_t;

    localparam logic [1:0] HDR_R1 = 2'd0;
    localparam logic [1:0] HDR_C1 = 2'd1;
    localparam logic [1:0] HDR_R2 = 2'd2;
    localparam logic [1:0] HDR_C2 = 2'd3;

endpackage

// File: rtl/matrix_elem_fifo.sv
// Synchronous element FIFO with full/empty flags.
// A push while full is taken only when a pop happens in the same cycle.
module matrix_elem_fifo #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wp;
    logic [AW:0]       rp;
    logic              do_pop;
    logic              do_push;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/matrix_stream_feeder.sv
// Serialises dims + buffered elements onto the loader nibble bus.
// Define MATRIX_FEEDER_DIM_CHECK_EN to also reject starts with c1 != r2.
module matrix_stream_feeder #(
    parameter int DATA_W     = 4,
    parameter int DIM_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DIM_W-1:0]  r1,
    input  logic [DIM_W-1:0]  c1,
    input  logic [DIM_W-1:0]  r2,
    input  logic [DIM_W-1:0]  c2,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data,
    output logic              ctrl_logic,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import matrix_pkg::*;

    localparam int TW = 2 * DIM_W + 1;

    feeder_state_t     state;
    logic [1:0]        hdr_idx;
    logic [DIM_W-1:0]  r1_q;
    logic [DIM_W-1:0]  c1_q;
    logic [DIM_W-1:0]  r2_q;
    logic [DIM_W-1:0]  c2_q;
    logic [TW-1:0]     total;
    logic [TW-1:0]     elem_cnt;
    logic [TW-1:0]     start_total;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] hdr_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              zero_dim;
    logic              reject;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == BODY) && !fifo_empty;

    assign zero_dim = (r1 == '0) || (c1 == '0) ||
                      (r2 == '0) || (c2 == '0);
`ifdef MATRIX_FEEDER_DIM_CHECK_EN
    assign reject = zero_dim || (c1 != r2);
`else
    assign reject = zero_dim;
`endif

    assign start_total = TW'(r1) * TW'(c1) +
                         TW'(r2) * TW'(c2);

    matrix_elem_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Select the latched dimension for the current header slot.
    always_comb begin
        hdr_word = '0;
        unique case (hdr_idx)
            HDR_R1: hdr_word = DATA_W'(r1_q);
            HDR_C1: hdr_word = DATA_W'(c1_q);
            HDR_R2: hdr_word = DATA_W'(r2_q);
            HDR_C2: hdr_word = DATA_W'(c2_q);
        endcase
    end

    // Transfer FSM with registered bus outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            hdr_idx    <= HDR_R1;
            r1_q       <= '0;
            c1_q       <= '0;
            r2_q       <= '0;
            c2_q       <= '0;
            total      <= '0;
            elem_cnt   <= '0;
            data       <= '0;
            ctrl_logic <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    out_valid  <= 1'b0;
                    ctrl_logic <= 1'b0;
                    if (start) begin
                        r1_q <= r1;
                        c1_q <= c1;
                        r2_q <= r2;
                        c2_q <= c2;
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            total      <= start_total;
                            elem_cnt   <= '0;
                            data       <= DATA_W'(r1);
                            ctrl_logic <= 1'b1;
                            out_valid  <= 1'b1;
                            busy       <= 1'b1;
                            hdr_idx    <= HDR_C1;
                            state      <= HDR;
                        end
                    end
                end
                HDR: begin
                    data       <= hdr_word;
                    ctrl_logic <= 1'b1;
                    out_valid  <= 1'b1;
                    if (hdr_idx == HDR_C2) begin
                        hdr_idx <= HDR_R1;
                        state   <= BODY;
                    end else begin
                        hdr_idx <= hdr_idx + 2'd1;
                    end
                end
                BODY: begin
                    ctrl_logic <= 1'b0;
                    if (pop) begin
                        data      <= fifo_rdata;
                        out_valid <= 1'b1;
                        elem_cnt  <= elem_cnt + TW'(1);
                        if (elem_cnt + TW'(1) == total)
                            state <= FIN;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                FIN: begin
                    out_valid  <= 1'b0;
                    ctrl_logic <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
